// File: rtl/aes_stream_scheduler.sv
// rtl/aes_stream_scheduler.sv - two-requester scheduler for a shared pipelined AES-128 core with drain-before-rekey
module aes_stream_scheduler #(
    parameter int LATENCY    = 10,
    parameter int KEY_SETTLE = 11,
    localparam int IW = $clog2(LATENCY + 2),
    localparam int SW = $clog2(KEY_SETTLE + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req0_valid_i,
    input  logic [127:0]  req0_data_i,
    output logic          req0_ready_o,
    input  logic          req1_valid_i,
    input  logic [127:0]  req1_data_i,
    output logic          req1_ready_o,
    input  logic          key_valid_i,
    input  logic [127:0]  key_in_i,
    output logic          key_ready_o,
    output logic [127:0]  core_data_in_o,
    output logic [127:0]  core_key_o,
    input  logic [127:0]  core_data_out_i,
    output logic          rsp0_valid_o,
    output logic          rsp1_valid_o,
    output logic [127:0]  rsp_data_o,
    output logic [IW-1:0] inflight_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {NOKEY, SETTLE, RUN, DRAIN} state_t;

    state_t          state_q;
    logic [SW-1:0]   settle_q;
    logic            last_grant_q;
    logic [127:0]    key_q;
    logic [127:0]    data_q;
    logic [127:0]    rsp_data_q;
    logic [LATENCY:0] tag_v_q;
    logic [LATENCY:0] tag_id_q;
    logic            rsp0_q;
    logic            rsp1_q;
    logic [IW-1:0]   inflight_q;
    logic [IW-1:0]   inflight_d;

    logic grant0, grant1, run, accept, accept_id, rsp_load, key_hs;

    // The requester not granted last has priority; a lone valid requester always wins.
    assign run       = (state_q == RUN);
    assign grant0    = req0_valid_i & (~req1_valid_i | last_grant_q);
    assign grant1    = req1_valid_i & (~req0_valid_i | ~last_grant_q);
    assign req0_ready_o = run & ~key_valid_i & grant0;
    assign req1_ready_o = run & ~key_valid_i & grant1;
    assign key_ready_o  = (state_q == NOKEY) | ((state_q == DRAIN) & (inflight_q == '0));
    assign key_hs    = key_valid_i & key_ready_o;
    assign accept    = req0_ready_o | req1_ready_o;
    assign accept_id = req1_ready_o;
    assign rsp_load  = tag_v_q[LATENCY];

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !rsp_load) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!accept && rsp_load) begin
            inflight_d = inflight_q - IW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= NOKEY;
            settle_q     <= '0;
            last_grant_q <= 1'b1;
            key_q        <= '0;
            data_q       <= '0;
            rsp_data_q   <= '0;
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            inflight_q   <= '0;
        end else begin
            // Tag pipe mirrors the core so each ciphertext is routed back to its issuer.
            tag_v_q    <= {tag_v_q[LATENCY-1:0], accept};
            tag_id_q   <= {tag_id_q[LATENCY-1:0], accept_id};
            inflight_q <= inflight_d;
            rsp0_q     <= rsp_load & ~tag_id_q[LATENCY];
            rsp1_q     <= rsp_load & tag_id_q[LATENCY];
            if (rsp_load) begin
                rsp_data_q <= core_data_out_i;
            end
            if (accept) begin
                data_q       <= accept_id ? req1_data_i : req0_data_i;
                last_grant_q <= accept_id;
            end
            case (state_q)
                NOKEY, DRAIN: begin
                    if (key_hs) begin
                        key_q    <= key_in_i;
                        settle_q <= SW'(KEY_SETTLE);
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    settle_q <= settle_q - SW'(1);
                    if (settle_q == SW'(1)) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (key_valid_i) begin
                        state_q <= DRAIN;
                    end
                end
                default: state_q <= NOKEY;
            endcase
        end
    end

    assign core_data_in_o = data_q;
    assign core_key_o     = key_q;
    assign rsp0_valid_o   = rsp0_q;
    assign rsp1_valid_o   = rsp1_q;
    assign rsp_data_o     = rsp_data_q;
    assign inflight_o     = inflight_q;
    assign busy_o         = (inflight_q != '0);

endmodule

// File: tb/tb_aes_stream_scheduler.sv
// tb/tb_aes_stream_scheduler.sv - randomized bench with an AES core model and a transaction-level scoreboard
module tb_aes_stream_scheduler;

    localparam int LATENCY    = 10;
    localparam int KEY_SETTLE = 11;
    localparam int IW         = $clog2(LATENCY + 2);

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0, key_valid = 1'b0;
    logic [127:0]  req0_data = '0, req1_data = '0, key_in = '0;
    logic          req0_ready, req1_ready, key_ready;
    logic [127:0]  core_data_in, core_key, rsp_data;
    logic [127:0]  core_data_out = '0;
    logic          rsp0_valid, rsp1_valid, busy;
    logic [IW-1:0] inflight;

    always #5 clk = ~clk;

    aes_stream_scheduler #(.LATENCY(LATENCY), .KEY_SETTLE(KEY_SETTLE)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_ready_o(req0_ready),
        .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_ready_o(req1_ready),
        .key_valid_i(key_valid), .key_in_i(key_in), .key_ready_o(key_ready),
        .core_data_in_o(core_data_in), .core_key_o(core_key), .core_data_out_i(core_data_out),
        .rsp0_valid_o(rsp0_valid), .rsp1_valid_o(rsp1_valid), .rsp_data_o(rsp_data),
        .inflight_o(inflight), .busy_o(busy)
    );

    // AES-128 reference arithmetic
    logic [7:0] sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc = 8'h01;
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Core model: ten-cycle pipe; output is corrupted if the key changed or had not settled for that block.
    logic [127:0] st_data  [LATENCY] = '{default: '0};
    int           st_entry [LATENCY] = '{default: 0};
    int           core_cyc = 0;
    int           keychg   = -1000;
    logic [127:0] prev_key = '0;

    always @(posedge clk) begin
        core_cyc <= core_cyc + 1;
        prev_key <= core_key;
        if (core_key != prev_key) keychg <= core_cyc;
        st_data[0]  <= core_data_in;
        st_entry[0] <= core_cyc;
        for (int i = 1; i < LATENCY; i++) begin
            st_data[i]  <= st_data[i-1];
            st_entry[i] <= st_entry[i-1];
        end
        if (st_entry[LATENCY-2] >= keychg + KEY_SETTLE)
            core_data_out <= aes_enc(st_data[LATENCY-2], core_key);
        else
            core_data_out <= ~aes_enc(st_data[LATENCY-2], core_key);
    end

    // Scoreboard and transaction-level reference
    typedef struct { int due; int id; logic [127:0] ct; } pend_t;
    pend_t        pend [$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           m_cyc = 0;
    int           m_run_from = 0;
    int           m_last = 1;
    bit           m_have_key = 0, m_drain = 0, m_key_hs = 0;
    logic [127:0] m_key = '0;
    logic [1:0]   m_rsp_v = '0;
    logic [127:0] m_rsp_data = '0;
    bit           e_run, e_kr, e_g0, e_g1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic compute_exp();
        e_run = m_have_key && !m_drain && (m_cyc >= m_run_from);
        e_kr  = !m_have_key || (m_drain && pend.size() == 0);
        e_g0  = e_run && !key_valid && req0_valid && (!req1_valid || m_last == 1);
        e_g1  = e_run && !key_valid && req1_valid && (!req0_valid || m_last == 0);
    endtask

    task automatic model_edge();
        pend_t p;
        m_key_hs = 0;
        if (rst) begin
            m_have_key = 0; m_drain = 0; m_last = 1; m_key = '0;
            m_rsp_v = '0; m_rsp_data = '0;
            pend.delete();
        end else begin
            m_cyc++;
            m_rsp_v = '0;
            if (pend.size() > 0 && pend[0].due == m_cyc) begin
                m_rsp_v[pend[0].id] = 1'b1;
                m_rsp_data = pend[0].ct;
                pend.delete(0);
            end
            if (key_valid && e_kr) begin
                m_key = key_in; m_have_key = 1; m_drain = 0;
                m_run_from = m_cyc + KEY_SETTLE; m_key_hs = 1;
            end else if (e_run && key_valid) begin
                m_drain = 1;
            end else if (e_g0 || e_g1) begin
                p.due = m_cyc + LATENCY + 1;
                p.id  = e_g1 ? 1 : 0;
                p.ct  = aes_enc(e_g1 ? req1_data : req0_data, m_key);
                pend.push_back(p);
                m_last = p.id;
            end
        end
    endtask

    task automatic tick();
        #1;
        compute_exp();
        if (!rst) begin
            chk("req0_ready", 128'(req0_ready), 128'(e_g0));
            chk("req1_ready", 128'(req1_ready), 128'(e_g1));
            chk("key_ready",  128'(key_ready),  128'(e_kr));
            chk("rsp0_valid", 128'(rsp0_valid), 128'(m_rsp_v[0]));
            chk("rsp1_valid", 128'(rsp1_valid), 128'(m_rsp_v[1]));
            chk("rsp_data",   rsp_data,         m_rsp_data);
            chk("inflight",   128'(inflight),   128'(pend.size()));
            chk("busy",       128'(busy),       128'(pend.size() != 0));
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int n_wait, peak;

    initial begin
        init_sbox();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Known-answer block through the whole key/settle/run path
        key_valid = 1'b1; key_in = FIPS_KEY;
        tick();
        key_valid = 1'b0;
        req0_valid = 1'b1; req0_data = FIPS_PT;
        n_wait = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (req0_ready) break;
            n_wait++;
            tick();
        end
        chk("settle_cycles", 128'(n_wait), 128'(KEY_SETTLE));
        tick();
        req0_valid = 1'b0;
        n_wait = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            n_wait++;
            if (rsp0_valid) break;
        end
        chk("kat_latency", 128'(n_wait), 128'(LATENCY + 1));
        chk("kat_data", rsp_data, FIPS_CT);
        chk("kat_rsp1", 128'(rsp1_valid), 128'(0));

        // Both requesters contend for eight cycles
        peak = 0;
        for (int k = 0; k < 8; k++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_data = rand128(); req1_data = rand128();
            tick();
            if (int'(inflight) > peak) peak = int'(inflight);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("contend_peak", 128'(peak), 128'(8));
        chk("contend_drained", 128'(inflight), 128'(0));

        // Key change in the middle of a requester-1 stream
        for (int k = 0; k < 15; k++) begin
            req1_valid = 1'b1; req1_data = rand128();
            tick();
        end
        key_valid = 1'b1; key_in = rand128();
        for (int k = 0; k < 40; k++) begin
            req1_data = rand128();
            tick();
            if (m_key_hs) break;
        end
        key_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            req1_data = rand128();
            tick();
        end
        req1_valid = 1'b0;
        for (int k = 0; k < 15; k++) tick();

        // Reset with blocks in flight
        for (int k = 0; k < 5; k++) begin
            req0_valid = 1'b1; req0_data = rand128();
            tick();
        end
        req0_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) tick();

        // Randomized traffic, key changes and occasional resets
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            if (rst) begin
                key_valid = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
            end else begin
                req0_valid = ($urandom_range(0, 9) < 7);
                req1_valid = ($urandom_range(0, 9) < 7);
                req0_data = rand128(); req1_data = rand128();
                if (!(key_valid && !m_key_hs)) begin
                    key_valid = ($urandom_range(0, m_have_key ? 79 : 5) == 0);
                    if (key_valid) key_in = rand128();
                end
            end
            tick();
        end
        rst = 1'b0; key_valid = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 20; k++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
